// File: rtl/audio_nios_cpu_mul_pkg.sv
// Shared definitions for the audio Nios CPU sequential multiply unit.
// Contents:
//   - opcode encodings (low word / unsigned, mixed and signed high word)
//   - the controller state enum
//   - the partial-product count and a helper giving each partial product's
//     shift into the 64-bit accumulator
package audio_nios_cpu_mul_pkg;

  localparam int NUM_PP = 4;

  localparam logic [1:0] OP_MUL    = 2'd0;
  localparam logic [1:0] OP_MULXUU = 2'd1;
  localparam logic [1:0] OP_MULXSU = 2'd2;
  localparam logic [1:0] OP_MULXSS = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL0  = 3'd1,
    ST_MUL1  = 3'd2,
    ST_MUL2  = 3'd3,
    ST_MUL3  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_FIX   = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Partial products are lo*lo, hi*lo, lo*hi, hi*hi, so their weights are
  // 2^0, 2^16, 2^16 and 2^32 respectively.
  function automatic int unsigned pp_shift(input logic [$clog2(NUM_PP)-1:0] idx);
    case (idx)
      2'd0:    pp_shift = 0;
      2'd3:    pp_shift = 32;
      default: pp_shift = 16;
    endcase
  endfunction

endpackage

// File: rtl/audio_nios_cpu_mul16_reg.sv
// 16x16 unsigned multiplier with a registered 32-bit product.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low clear of the product register
//   a, b    - 16-bit unsigned operands
//   p       - product of the operands presented in the previous cycle
module audio_nios_cpu_mul16_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] p_d;
  logic [31:0] p_q;

  always_comb begin
    p_d = 32'(a) * 32'(b);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_q <= 32'd0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/audio_nios_cpu_mulx_seq.sv
// Sequential 32x32 multiply unit for the audio Nios CPU execute stage.
// One registered 16x16 unsigned multiplier is reused for four partial
// products; the 64-bit unsigned sum is then sign-corrected for the mixed and
// signed high-word opcodes.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset, aborts any operation
//   start   - request, accepted only while idle
//   op      - 0 MUL (low word), 1 MULXUU, 2 MULXSU, 3 MULXSS (high word)
//   src1    - multiplicand, captured on acceptance
//   src2    - multiplier, captured on acceptance
//   busy    - high from the cycle after acceptance through the done cycle
//   done    - one-cycle pulse when result is valid
//   result  - selected product word, held until the next done
module audio_nios_cpu_mulx_seq
  import audio_nios_cpu_mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [31:0] mul_p;

  logic [$clog2(NUM_PP)-1:0] pp_idx;
  logic                      pp_add;
  logic [31:0]               hi_fixed;
  logic                      sub_b;
  logic                      sub_a;

  // Controller: a fixed walk through the partial-product, drain and fix
  // steps; only the idle state waits on start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_MUL0;
      ST_MUL0:  state_d = ST_MUL1;
      ST_MUL1:  state_d = ST_MUL2;
      ST_MUL2:  state_d = ST_MUL3;
      ST_MUL3:  state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_FIX;
      ST_FIX:   state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Operand-half selection for the shared multiplier.
  always_comb begin
    mul_a = a_q[15:0];
    mul_b = b_q[15:0];
    case (state_q)
      ST_MUL1: mul_a = a_q[31:16];
      ST_MUL2: mul_b = b_q[31:16];
      ST_MUL3: begin
        mul_a = a_q[31:16];
        mul_b = b_q[31:16];
      end
      default: ;
    endcase
  end

  audio_nios_cpu_mul16_reg u_mul16 (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (mul_a),
    .b       (mul_b),
    .p       (mul_p)
  );

  // The multiplier output lags its inputs by one cycle, so the product
  // issued in MULk is accumulated in the state after it.
  always_comb begin
    pp_add = 1'b1;
    pp_idx = '0;
    case (state_q)
      ST_MUL1:  pp_idx = 2'd0;
      ST_MUL2:  pp_idx = 2'd1;
      ST_MUL3:  pp_idx = 2'd2;
      ST_DRAIN: pp_idx = 2'd3;
      default:  pp_add = 1'b0;
    endcase
  end

  // Signed correction of the unsigned high word: a negative src1 read as
  // unsigned contributes an extra src2*2^32, and likewise for src2.
  always_comb begin
    sub_b    = (op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[31];
    sub_a    = (op_q == OP_MULXSS) && b_q[31];
    hi_fixed = acc_q[63:32] - (sub_b ? b_q : 32'd0) - (sub_a ? a_q : 32'd0);
  end

  // Datapath next-state: operand capture, accumulation and result update.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = result_q;
    if (state_q == ST_IDLE && start) begin
      a_d   = src1;
      b_d   = src2;
      op_d  = op;
      acc_d = 64'd0;
    end else if (pp_add) begin
      acc_d = acc_q + ({32'd0, mul_p} << pp_shift(pp_idx));
    end
    if (state_q == ST_FIX) begin
      result_d = (op_q == OP_MUL) ? acc_q[31:0] : hi_fixed;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= OP_MUL;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_audio_nios_cpu_mulx_seq.sv
// Self-checking bench for audio_nios_cpu_mulx_seq. A cycle-level reference
// model computes the product with plain 64-bit arithmetic and tracks the
// expected busy/done/result timeline; a negedge process compares the DUT to
// it every cycle, and directed vectors add literal expectations.
module tb_audio_nios_cpu_mulx_seq;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [1:0]  op      = 2'd0;
  logic [31:0] src1    = 32'd0;
  logic [31:0] src2    = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  audio_nios_cpu_mulx_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .src1    (src1),
    .src2    (src2),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Reference product: extend each operand by its signedness and keep the
  // requested word of the 64-bit product.
  function automatic logic [31:0] ref_mul(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (o == 2'd2 || o == 2'd3) ea = {{32{a[31]}}, a};
    if (o == 2'd3)              eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (o == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model timeline: cycles elapsed since acceptance (0 = idle). Result is
  // registered at the end of the sixth cycle and done shows in the seventh.
  int          m_phase   = 0;
  logic [31:0] m_pending = 32'd0;
  logic [31:0] m_result  = 32'd0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase   <= 0;
      m_pending <= 32'd0;
      m_result  <= 32'd0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase   <= 1;
        m_pending <= ref_mul(op, src1, src2);
      end
    end else if (m_phase == 6) begin
      m_phase  <= 7;
      m_result <= m_pending;
    end else if (m_phase == 7) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    check_output("busy",   {31'd0, busy}, {31'd0, (m_phase != 0)});
    check_output("done",   {31'd0, done}, {31'd0, (m_phase == 7)});
    check_output("result", result, m_result);
  end

  // Issue one operation and wait for done; checks latency and the result.
  task automatic apply_stimulus(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp,
                                input string name);
    int  n;
    bit  got;
    @(posedge clk); #1;
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n   = 1;
    got = 0;
    while (n <= 20 && !got) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout actual=no_done expected=done_within_20", name);
    end else begin
      check_output({name, "_latency"}, 32'(n), 32'd7);
      check_output({name, "_result"}, result, exp);
    end
  endtask

  initial begin
    int pulses;
    int last_done;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy",   {31'd0, busy}, 32'd0);
    check_output("rst_done",   {31'd0, done}, 32'd0);
    check_output("rst_result", result, 32'd0);
    reset_n = 1'b1;

    // Directed vectors.
    apply_stimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "uu_max");
    apply_stimulus(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "ss_m1m1");
    apply_stimulus(2'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "ss_m1p2");
    apply_stimulus(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "su_max");
    apply_stimulus(2'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, "mul_lo");
    apply_stimulus(2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "ss_minmin");
    apply_stimulus(2'd2, 32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, "su_min3");

    // Start held high: accepted every 8 cycles; operand noise while busy.
    @(posedge clk); #1;
    op = 2'd1; src1 = 32'h0001_0000; src2 = 32'h0001_0000; start = 1'b1;
    pulses    = 0;
    last_done = -1;
    for (int cyc = 0; cyc < 42; cyc++) begin
      @(posedge clk); #1;
      if (m_phase >= 1 && m_phase <= 6) begin
        op = 2'($urandom); src1 = $urandom; src2 = $urandom;
      end else begin
        op = 2'd1; src1 = 32'h0001_0000; src2 = 32'h0001_0000;
      end
      @(negedge clk);
      if (done) begin
        pulses++;
        check_output("b2b_result", result, 32'h0000_0001);
        if (last_done >= 0) check_output("b2b_spacing", 32'(cyc - last_done), 32'd8);
        last_done = cyc;
      end
    end
    check_output("b2b_pulses", 32'(pulses), 32'd5);
    start = 1'b0;
    repeat (10) @(posedge clk);

    // Reset asserted in the fourth busy cycle aborts the operation.
    @(posedge clk); #1;
    op = 2'd1; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("abort_busy",   {31'd0, busy}, 32'd0);
    check_output("abort_done",   {31'd0, done}, 32'd0);
    check_output("abort_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    apply_stimulus(2'd3, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, "after_rst");

    // Randomised sweep against the reference product.
    for (int i = 0; i < 1000; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 10 == 0) ra[31] = 1'b1;
      if (i % 7 == 0)  rb[31] = 1'b1;
      apply_stimulus(ro, ra, rb, ref_mul(ro, ra, rb), "rand");
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/audio_nios_cpu_mulx_seq.md
# audio_nios_cpu_mulx_seq

Sequential multiply unit for the audio Nios CPU. It accepts two 32-bit operands plus an opcode and produces either the low 32 bits (MUL) or the high 32 bits (MULXUU/MULXSU/MULXSS) of the 64-bit product. It reuses one registered 16x16 unsigned multiplier across four partial products, then applies signed correction. It sits beside the CPU's A-stage multiply cell and is used by the execute stage for high-half multiplies.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only in IDLE.
- op  input  2  0=MUL (low word), 1=MULXUU, 2=MULXSU (src1 signed, src2 unsigned), 3=MULXSS.
- src1  input  32  multiplicand, sampled when start is accepted.
- src2  input  32  multiplier, sampled when start is accepted.
- busy  output  1  high from the cycle after acceptance through the done cycle.
- done  output  1  one-cycle pulse; result is valid in this cycle.
- result  output  32  selected product word; held until the next done.

## Operation
- States and transitions:
  - IDLE → MUL0 → MUL1 → MUL2 → MUL3 → DRAIN → FIX → DONE → IDLE.
  - Only IDLE has a branch: it stays in IDLE unless start=1.
- Acceptance:
  - In IDLE with start=1, latch src1, src2 and op, and clear the 64-bit accumulator.
  - start outside IDLE is ignored, not queued.
- Partial products issued to the multiplier:
  - MUL0: a_lo·b_lo
  - MUL1: a_hi·b_lo
  - MUL2: a_lo·b_hi
  - MUL3: a_hi·b_hi
  - Each is an unsigned 16x16 → 32-bit product.
- Accumulation:
  - The product registered at the end of MULk is added in the following cycle.
  - Shift amounts: 0 for pp0, 16 for pp1 and pp2, 32 for pp3.
  - The last add happens in DRAIN.
  - The accumulator is 64-bit unsigned and wraps mod 2^64.
- FIX computes the high-word correction mod 2^32:
  - op=MULXSU or MULXSS and src1[31]=1: subtract src2 from the high word.
  - op=MULXSS and src2[31]=1: subtract src1 from the high word.
  - For op=MULXSS with both sign bits set, apply both subtractions.
  - op=MUL and op=MULXUU: no correction.
  - At the end of FIX, register result = op==0 ? acc[31:0] : corrected acc[63:32].
- DONE: done=1 for exactly one cycle, then return to IDLE.

## Timing
- Start accepted in cycle T:
  - busy=1 in cycles T+1 through T+7.
  - done=1 only in cycle T+7.
  - Back in IDLE at T+8.
- Fixed latency of 7 cycles, independent of operands and op.
- Maximum issue rate: one operation per 8 cycles. A start in cycle T+7 is ignored; a start in T+8 is accepted.
- Values while reset_n=0 (asynchronous):
  - state=IDLE
  - busy=0, done=0
  - result=0
  - accumulator, latched operands and multiplier register all 0
- Reset asserted mid-operation aborts the operation. No done is emitted, and result reads 0 after reset.
- Multiplier pipeline latency is exactly 1 cycle, and its register is cleared by ~reset_n.

## Structure
- Package audio_nios_cpu_mul_pkg holds:
  - op encodings: OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS;
  - the state enum;
  - constant NUM_PP=4.
- Sub-module audio_nios_cpu_mul16_reg:
  - 16x16 unsigned multiplier with a registered 32-bit output and asynchronous clear;
  - one instance.
- The top level contains the FSM, operand-half muxing, the accumulator, the correction logic and the result register.

## Test plan
- Reset, then op=1, src1=src2=0xFFFFFFFF, start in T → done only in T+7, result=0xFFFFFFFE, busy high T+1..T+7.
- op=3, src1=src2=0xFFFFFFFF (−1·−1) → result=0x00000000. op=3, src1=0xFFFFFFFF, src2=0x00000002 → result=0xFFFFFFFF.
- op=2, src1=0xFFFFFFFF, src2=0xFFFFFFFF → result=0xFFFFFFFF. op=0, src1=0x12345678, src2=0x00000010 → result=0x23456780.
- start held high continuously with op=1, src1=src2=0x00010000 → done pulses spaced exactly 8 cycles apart, each with result=0x00000001; operand changes while busy have no effect.
- Assert reset_n=0 in cycle T+4 of an operation → busy, done and result go to 0 immediately with no done pulse; the next operation after release produces correct results.
- Randomized sweep of 1000 operand/op pairs against a 64-bit reference model → every result matches and latency is always 7.
